// File: rtl/rob_shift_array.sv
// Compacting ordered storage for the reorder-buffer queue: entries stay packed
// toward slot 0, with shift-based insert and remove at any position each cycle.
module rob_shift_array #(
  parameter int p_depth     = 8,
  parameter int p_ptrwidth  = 5,
  parameter int p_chanwidth = 32,
  parameter int p_bitwidth  = p_ptrwidth + p_chanwidth
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ins_val,
  output logic                          ins_rdy,
  input  logic [$clog2(p_depth)-1:0]    ins_idx,
  input  logic [p_bitwidth-1:0]         ins_data,
  input  logic                          rem_val,
  input  logic [$clog2(p_depth)-1:0]    rem_idx,
  output logic [$clog2(p_depth+1)-1:0]  count,
  output logic                          head_val,
  output logic [p_bitwidth-1:0]         head_data,
  output logic [p_depth*p_bitwidth-1:0] entry_data,
  output logic [p_depth-1:0]            entry_valid,
  output logic                          err
);

  localparam int IW = $clog2(p_depth);
  localparam int CW = $clog2(p_depth + 1);

  logic [p_bitwidth-1:0] slots    [p_depth];
  logic [p_bitwidth-1:0] removed  [p_depth];
  logic [p_bitwidth-1:0] slot_nxt [p_depth];
  logic [CW-1:0]         count_post;
  logic [CW-1:0]         count_nxt;
  logic                  rem_ok;
  logic                  ins_fit;
  logic                  ins_ok;
  logic                  err_set;

  always_comb begin
    rem_ok     = rem_val && (CW'(rem_idx) < count);
    count_post = count - CW'(rem_ok);
    ins_rdy    = (count < CW'(p_depth)) || rem_ok;
    ins_fit    = CW'(ins_idx) <= count_post;
    ins_ok     = ins_val && ins_rdy && ins_fit;
    err_set    = (rem_val && !rem_ok) || (ins_val && ins_rdy && !ins_fit);
    count_nxt  = count_post + CW'(ins_ok);
  end

  // Remove first, then insert into the compacted order; vacated slots are
  // already zero, so shifting them in keeps the unoccupied tail cleared.
  always_comb begin
    for (int unsigned k = 0; k < p_depth; k++) removed[k] = slots[k];
    if (rem_ok) begin
      for (int unsigned k = 0; k < p_depth - 1; k++)
        if (IW'(k) >= rem_idx) removed[k] = slots[k+1];
      removed[p_depth-1] = '0;
    end
    for (int unsigned k = 0; k < p_depth; k++) slot_nxt[k] = removed[k];
    if (ins_ok) begin
      for (int unsigned k = 1; k < p_depth; k++)
        if (IW'(k) > ins_idx) slot_nxt[k] = removed[k-1];
      for (int unsigned k = 0; k < p_depth; k++)
        if (IW'(k) == ins_idx) slot_nxt[k] = ins_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < p_depth; k++) slots[k] <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < p_depth; k++) slots[k] <= slot_nxt[k];
      count <= count_nxt;
      err   <= err | err_set;
    end
  end

  always_comb begin
    head_val  = count != '0;
    head_data = slots[0];
    entry_data  = '0;
    entry_valid = '0;
    for (int unsigned k = 0; k < p_depth; k++) begin
      entry_data[k*p_bitwidth +: p_bitwidth] = slots[k];
      entry_valid[k] = CW'(k) < count;
    end
  end

endmodule

// File: tb/tb_rob_shift_array.sv
// Directed bench for rob_shift_array: the driver queues hand-computed expected
// state per operation, a negedge monitor pops and compares against the outputs.
module tb_rob_shift_array;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ins_val = 1'b0;
  logic         rem_val = 1'b0;
  logic [2:0]   ins_idx = '0;
  logic [2:0]   rem_idx = '0;
  logic [36:0]  ins_data = '0;
  logic         ins_rdy;
  logic [3:0]   count;
  logic         head_val;
  logic [36:0]  head_data;
  logic [295:0] entry_data;
  logic [7:0]   entry_valid;
  logic         err;

  rob_shift_array #(.p_depth(8), .p_ptrwidth(5), .p_chanwidth(32)) dut (
    .clk(clk), .rst(rst), .ins_val(ins_val), .ins_rdy(ins_rdy),
    .ins_idx(ins_idx), .ins_data(ins_data), .rem_val(rem_val),
    .rem_idx(rem_idx), .count(count), .head_val(head_val),
    .head_data(head_data), .entry_data(entry_data),
    .entry_valid(entry_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   cnt;
    logic         er;
    logic [295:0] ed;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [295:0] act, input logic [295:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte k of the 64-bit pattern is the expected contents of slot k.
  function automatic logic [295:0] expand(input logic [63:0] b);
    logic [295:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*37 +: 37] = 37'(b[k*8 +: 8]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [7:0] ev;
      e  = sb.pop_front();
      ev = '0;
      for (int k = 0; k < 8; k++) if (k < int'(e.cnt)) ev[k] = 1'b1;
      chk("count",       296'(count),       296'(e.cnt));
      chk("err",         296'(err),         296'(e.er));
      chk("head_val",    296'(head_val),    296'(e.cnt != 4'd0));
      chk("head_data",   296'(head_data),   296'(e.ed[36:0]));
      chk("entry_data",  entry_data,        e.ed);
      chk("entry_valid", 296'(entry_valid), 296'(ev));
    end
  end

  task automatic op(input logic iv, input int ii, input logic [36:0] id,
                    input logic rv, input int ri, input logic erdy,
                    input int ecnt, input logic eerr, input logic [63:0] es,
                    input string nm);
    exp_t e;
    ins_val  = iv;
    ins_idx  = 3'(ii);
    ins_data = id;
    rem_val  = rv;
    rem_idx  = 3'(ri);
    #1 chk({nm, " ins_rdy"}, 296'(ins_rdy), 296'(erdy));
    @(posedge clk);
    e.cnt = 4'(ecnt);
    e.er  = eerr;
    e.ed  = expand(es);
    sb.push_back(e);
    #1;
    ins_val = 1'b0;
    rem_val = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [63:0] acc;
    #3;
    chk("reset count",   296'(count),   296'(0));
    chk("reset err",     296'(err),     296'(0));
    chk("reset head",    296'(head_val), 296'(0));
    chk("reset data",    entry_data,    296'(0));
    chk("reset ins_rdy", 296'(ins_rdy), 296'(1));
    @(negedge clk);
    #1 rst = 1'b1;

    // append A,B,C then middle insert and head remove
    op(1, 0, 37'hA, 0, 0, 1, 1, 0, 64'h00_00_00_00_00_00_00_0A, "ins A@0");
    op(1, 1, 37'hB, 0, 0, 1, 2, 0, 64'h00_00_00_00_00_00_0B_0A, "ins B@1");
    op(1, 2, 37'hC, 0, 0, 1, 3, 0, 64'h00_00_00_00_00_0C_0B_0A, "ins C@2");
    op(1, 1, 37'hD, 0, 0, 1, 4, 0, 64'h00_00_00_00_0C_0B_0D_0A, "ins D@1");
    op(0, 0, 37'h0, 1, 0, 1, 3, 0, 64'h00_00_00_00_00_0C_0B_0D, "rem @0");

    // full array, refused insert, then insert-at-tail with remove
    do_reset();
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      acc[i*8 +: 8] = 8'(i + 1);
      op(1, i, 37'(i + 1), 0, 0, 1, i + 1, 0, acc, "fill");
    end
    op(1, 0, 37'h77, 0, 0, 0, 8, 0, 64'h08_07_06_05_04_03_02_01, "full ins only");
    op(1, 7, 37'h9, 1, 2, 1, 8, 0, 64'h09_08_07_06_05_04_02_01, "full ins@7 rem@2");

    // simultaneous insert/remove in both directions
    do_reset();
    for (int i = 0; i < 4; i++) begin
      acc = '0;
      for (int j = 0; j <= i; j++) acc[j*8 +: 8] = 8'(j + 1);
      op(1, i, 37'(i + 1), 0, 0, 1, i + 1, 0, acc, "fill4");
    end
    op(1, 3, 37'h5, 1, 0, 1, 4, 0, 64'h00_00_00_00_05_04_03_02, "rem@0 ins5@3");
    op(1, 0, 37'h6, 1, 3, 1, 4, 0, 64'h00_00_00_00_04_03_02_06, "rem@3 ins6@0");

    // illegal operations at count 2
    do_reset();
    op(1, 0, 37'h1,  0, 0, 1, 1, 0, 64'h00_00_00_00_00_00_00_01, "ins 1@0");
    op(1, 1, 37'h2,  0, 0, 1, 2, 0, 64'h00_00_00_00_00_00_02_01, "ins 2@1");
    op(0, 0, 37'h0,  1, 5, 1, 2, 1, 64'h00_00_00_00_00_00_02_01, "bad rem@5");
    op(1, 4, 37'h33, 0, 0, 1, 2, 1, 64'h00_00_00_00_00_00_02_01, "bad ins@4");
    op(1, 2, 37'h3,  0, 0, 1, 3, 1, 64'h00_00_00_00_00_03_02_01, "ins 3@2");

    // empty boundary: removal illegal, insert@0 still legal
    do_reset();
    op(1, 0, 37'h44, 1, 0, 1, 1, 1, 64'h00_00_00_00_00_00_00_44, "empty rem+ins");

    // asynchronous reset between edges
    do_reset();
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      acc[i*8 +: 8] = 8'(i + 1);
      op(1, i, 37'(i + 1), 0, 0, 1, i + 1, 0, acc, "fill5");
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async count",   296'(count),       296'(0));
    chk("async head",    296'(head_val),    296'(0));
    chk("async data",    entry_data,        296'(0));
    chk("async valid",   296'(entry_valid), 296'(0));
    chk("async ins_rdy", 296'(ins_rdy),     296'(1));
    @(negedge clk);
    #1 rst = 1'b1;
    op(1, 0, 37'h5, 0, 0, 1, 1, 0, 64'h00_00_00_00_00_00_00_05, "post-reset ins@0");

    repeat (3) @(negedge clk);
    #1 chk("scoreboard drained", 296'(sb.size()), 296'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_shift_array.md
# rob_shift_array

Parametrised ordered storage array for the reorder-buffer queue: `p_depth` entries of `{ptr, chan}` data kept packed toward slot 0, with per-cycle insertion at any position and removal from any position, each performed by shifting neighbouring entries. It generalises the single-entry multi-input register into a complete compacting queue with occupancy tracking, a ready handshake and illegal-operation detection. It sits between the ROB allocation logic (insert) and the commit/flush logic (remove).

## Interface
- `p_depth`, 8: number of entries, at least 2.
- `p_ptrwidth`, 5: pointer field width.
- `p_chanwidth`, 32: channel data field width.
- `p_bitwidth`, `p_ptrwidth + p_chanwidth`: entry width. Data is `{ptr, chan}`, with ptr in the MSBs.
- `clk` input 1: clock. All state updates on the posedge.
- `rst` input 1: asynchronous, active-low reset. Low means reset.
- `ins_val` input 1: insert request.
- `ins_rdy` output 1: insert will be accepted this cycle.
- `ins_idx` input `$clog2(p_depth)`: insertion slot.
- `ins_data` input `p_bitwidth`: entry to insert.
- `rem_val` input 1: remove request.
- `rem_idx` input `$clog2(p_depth)`: slot to remove.
- `count` output `$clog2(p_depth+1)`: number of occupied slots.
- `head_val` output 1: `count != 0`.
- `head_data` output `p_bitwidth`: slot 0 contents.
- `entry_data` output `p_depth*p_bitwidth`: all slots, slot k at bits `[k*p_bitwidth +: p_bitwidth]`.
- `entry_valid` output `p_depth`: bit k is `k < count`.
- `err` output 1: sticky illegal-operation flag.

## Operation
- Occupied slots are always 0..count-1, in order. Unoccupied slots hold 0.
- Removal is legal when `rem_val` is high and `rem_idx < count`.
  - Slots `rem_idx+1..count-1` shift toward slot 0 (slot k takes slot k+1).
  - Slot `count-1` becomes 0.
  - `count` decrements.
- Insertion is accepted when `ins_val & ins_rdy`. `ins_idx` is interpreted against the post-removal order and post-removal count `c'`.
  - Insertion is legal only if `ins_idx <= c'`.
  - Slots `ins_idx..c'-1` shift toward the tail (slot k takes slot k-1).
  - Slot `ins_idx` takes `ins_data`.
  - `count` increments.
- `ins_rdy = (count < p_depth) | legal removal this cycle`. This is combinational from `rem_val`/`rem_idx`; `ins_rdy` does not depend on `ins_val`.
- Simultaneous legal insert and remove:
  - `count` is unchanged.
  - Each slot k selects exactly one of hold, L[k+1], L[k-1] or `ins_data`.
  - The selection is derived from k against `rem_idx` and `ins_idx` as "remove first, then insert".
- Illegal removal (`rem_val` high, `rem_idx >= count`):
  - The removal is ignored and `err` is set.
  - `ins_rdy` and insertion legality use the unmodified `count`.
- Illegal insertion (`ins_val` high, `ins_rdy` high, `ins_idx > c'`):
  - The insertion is ignored, with no shift and no count change, and `err` is set.
  - A legal removal in the same cycle still completes.
- `ins_val` with `ins_rdy` low (full, no legal removal) is not an error. The request is simply not accepted and state holds.
- `err` clears only on reset.

## Timing
- Reset (`rst` low), asynchronous:
  - All slots become 0; `count`, `head_val` and `err` become 0.
  - `ins_rdy` is 1 while `rst` is low.
  - Reset asserted mid-operation discards any in-flight request.
  - The first update after deassertion is at the next posedge with `rst` high.
- Insert and remove take effect at the posedge where they are requested and are visible on all outputs in the following cycle (latency 1).
- `head_data`, `entry_data`, `entry_valid`, `count`, `head_val` and `err` are registered or derived only from registers. `ins_rdy` is the only combinational output.
- Full boundary: with `count == p_depth`, insert plus legal remove is accepted, including `ins_idx == p_depth-1` (append after removal).
- Empty boundary: with `count == 0`, `ins_idx == 0` is legal and any `rem_val` is an error.

## Test plan
- Reset then append: insert 0xA@0, 0xB@1, 0xC@2 on consecutive cycles -> count=3, slots 0..2 = A,B,C, `head_data`=A, `entry_valid`=0b00000111.
- Middle insert: from A,B,C, insert 0xD@1 -> A,D,B,C with count=4. Then remove @0 -> D,B,C, count=3, slot 3 = 0.
- Full plus simultaneous: fill 8 entries 1..8, assert `ins_val` alone -> `ins_rdy`=0 and no change. Then insert 0x9@7 with remove @2 -> 1,2,4,5,6,7,8,9, count=8, err=0.
- Simultaneous both directions: from 1,2,3,4 (count 4), remove @0 and insert 0x5@3 -> 2,3,4,5; remove @3 and insert 0x6@0 -> 6,2,3,4.
- Illegal ops: at count=2, remove @5 -> no change, err=1. Then insert @4 -> ignored, err stays 1, count=2. Legal insert @2 still works afterwards.
- Async reset mid-op: assert `rst` low between edges with count=5 -> outputs zero immediately without a clock edge. Release, then a legal insert @0 -> count=1.
